conv1d_pe_mf: RTL

Multi-filter 1D convolution processing element: the parametrised successor of the single-filter PE. It streams one IFMap row through a circular scratchpad and convolves it against NUM_FILT filters in parallel with a programmable stride and filter size. It emits one packed partial-sum word per window through a FIFO. It sits between the global IFMap/filter buffers and the psum collection network, and it replaces the single-filter PE in arrays where filter reuse across rows matters.

---
 rtl/conv1d_pe_mf.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/conv1d_pe_mf.sv
// ---------------------------------------------------------------------------
// conv1d_pe_mf : multi-filter 1D convolution processing element
//
// Streams one IFMap row through a circular scratchpad and convolves it against
// NUM_FILT filters in parallel, with a programmable stride and filter size.
// Each window yields one packed partial-sum word, emitted through a FIFO.
//
// Build option: define PSUM_SATURATE_EN to saturate each accumulator to the
// signed PSUM_W range on store. Without it, the low PSUM_W bits are kept
// (two's-complement wrap).
//
// Ports
//   clk, rst             clock; synchronous active-low reset
//   start                one-cycle pulse, accepted only when idle
//   reuse_filt           sampled with start; 1 skips the filter load
//   stride, filter_size  sampled with start; clamped to legal ranges
//   f_data/f_valid/f_ready              filter stream, filter-major order
//   if_data/if_valid/if_last/if_ready   IFMap stream; if_last ends the row
//   ps_data/ps_valid/ps_ready           psum stream; filter k at [k*PSUM_W +: PSUM_W]
//   busy                 high whenever the FSM is not idle
//   done                 one-cycle pulse at the end of a row
// ---------------------------------------------------------------------------
module conv1d_pe_mf #(
    parameter int DATA_W      = 8,
    parameter int PSUM_W      = 20,
    parameter int NUM_FILT    = 2,
    parameter int MAX_FSIZE   = 8,
    parameter int IFMAP_DEPTH = 16,
    parameter int PSUM_DEPTH  = 8,
    parameter int STRIDE_W    = 3,
    parameter int FSIZE_W     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       reuse_filt,
    input  logic [STRIDE_W-1:0]        stride,
    input  logic [FSIZE_W-1:0]         filter_size,
    input  logic [DATA_W-1:0]          f_data,
    input  logic                       f_valid,
    output logic                       f_ready,
    input  logic [DATA_W-1:0]          if_data,
    input  logic                       if_valid,
    input  logic                       if_last,
    output logic                       if_ready,
    output logic [NUM_FILT*PSUM_W-1:0] ps_data,
    output logic                       ps_valid,
    input  logic                       ps_ready,
    output logic                       busy,
    output logic                       done
);

    localparam int ACC_W   = 2*DATA_W + $clog2(MAX_FSIZE);
    localparam int PTR_W   = $clog2(IFMAP_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TAP_W   = $clog2(MAX_FSIZE);
    localparam int CFG_W   = (STRIDE_W > FSIZE_W) ? STRIDE_W : FSIZE_W;
    localparam int FILT_W  = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
    localparam int FPTR_W  = (PSUM_DEPTH > 1) ? $clog2(PSUM_DEPTH) : 1;
    localparam int FCNT_W  = $clog2(PSUM_DEPTH + 1);
    localparam int EXT_W   = (ACC_W > PSUM_W) ? ACC_W : PSUM_W;
    localparam int WORD_W  = NUM_FILT * PSUM_W;

    localparam logic [CFG_W-1:0] ONE    = CFG_W'(1);
    localparam logic [CFG_W-1:0] MAX_FS = CFG_W'(MAX_FSIZE);

    typedef enum logic [2:0] {IDLE, LOAD_F, WAIT_WIN, MAC, STORE, DONE} state_t;

    state_t state, state_next;

    // Configuration and control registers
    logic [CFG_W-1:0]  fs_q, stride_q, fs_eff, st_eff, fs_last;
    logic [CFG_W-1:0]  tap, ld_tap;
    logic [FILT_W-1:0] ld_filt;
    logic [PTR_W-1:0]  wr_ptr, win_start, rd_addr;
    logic [CNT_W-1:0]  count;
    logic              last_seen;

    // Scratchpads and accumulators
    logic signed [DATA_W-1:0]   ifbuf [IFMAP_DEPTH];
    logic signed [DATA_W-1:0]   filt  [NUM_FILT][MAX_FSIZE];
    logic signed [ACC_W-1:0]    acc   [NUM_FILT];
    logic signed [2*DATA_W-1:0] prod  [NUM_FILT];

    // Output FIFO
    logic [WORD_W-1:0] fifo_mem [PSUM_DEPTH];
    logic [FPTR_W-1:0] fifo_wr, fifo_rd;
    logic [FCNT_W-1:0] fifo_cnt;
    logic [WORD_W-1:0] psum_word;
    logic              fifo_full, push, pop, f_fire, if_fire;

    // Accumulator to psum conversion: sign-extend first so a psum wider than
    // the accumulator still carries the correct sign.
    function automatic logic [PSUM_W-1:0] to_psum(input logic signed [ACC_W-1:0] a);
        logic signed [EXT_W-1:0] e;
`ifdef PSUM_SATURATE_EN
        logic signed [EXT_W-1:0] ps_max, ps_min;
        ps_max = {{(EXT_W-PSUM_W+1){1'b0}}, {(PSUM_W-1){1'b1}}};
        ps_min = {{(EXT_W-PSUM_W+1){1'b1}}, {(PSUM_W-1){1'b0}}};
`endif
        e = EXT_W'(a);
`ifdef PSUM_SATURATE_EN
        if (e > ps_max) e = ps_max;
        else if (e < ps_min) e = ps_min;
`endif
        return e[PSUM_W-1:0];
    endfunction

    // Config clamping: size 0 -> 1, size > MAX_FSIZE -> MAX_FSIZE;
    // stride 0 -> 1, stride > effective size -> effective size.
    // NOTE: every variable assigned in always_comb gets a value up front, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        fs_eff = CFG_W'(filter_size);
        if (filter_size == '0)              fs_eff = ONE;
        else if (CFG_W'(filter_size) > MAX_FS) fs_eff = MAX_FS;
        st_eff = CFG_W'(stride);
        if (stride == '0)          st_eff = ONE;
        else if (st_eff > fs_eff)  st_eff = fs_eff;
    end

    assign fs_last   = fs_q - ONE;
    assign rd_addr   = win_start + PTR_W'(tap);
    assign fifo_full = (fifo_cnt == FCNT_W'(PSUM_DEPTH));
    assign ps_valid  = (fifo_cnt != '0);
    assign pop       = ps_valid & ps_ready;
    // A full FIFO still accepts a push in a cycle where it is also popped.
    assign push      = (state == STORE) & (~fifo_full | pop);
    assign f_fire    = f_valid & f_ready;
    assign if_fire   = if_valid & if_ready;
    assign if_ready  = busy & ~last_seen & (count < CNT_W'(IFMAP_DEPTH));
    assign ps_data   = ps_valid ? fifo_mem[fifo_rd] : '0;

    // State register
    // NOTE: rst is synchronous, so it is tested inside the clocked block and
    // stays out of the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic and FSM-decoded outputs
    always_comb begin
        state_next = state;
        f_ready    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = reuse_filt ? WAIT_WIN : LOAD_F;
            end
            LOAD_F: begin
                f_ready = 1'b1;
                if (f_fire && ld_tap == fs_last && ld_filt == FILT_W'(NUM_FILT-1))
                    state_next = WAIT_WIN;
            end
            WAIT_WIN: begin
                if (count >= CNT_W'(fs_q)) state_next = MAC;
                else if (last_seen)        state_next = DONE;
            end
            MAC:   if (tap == fs_last) state_next = STORE;
            STORE: if (push) state_next = WAIT_WIN;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < NUM_FILT; k++)
            prod[k] = ifbuf[rd_addr] * filt[k][tap[TAP_W-1:0]];
    end

    always_comb begin
        psum_word = '0;
        for (int k = 0; k < NUM_FILT; k++)
            psum_word[k*PSUM_W +: PSUM_W] = to_psum(acc[k]);
    end

    // NOTE: the IFMap buffer and FIFO storage are not reset; the pointers and
    // counts decide what is valid. The filter spad is reset because a reuse
    // start straight after reset must see all-zero taps.
    always_ff @(posedge clk) begin
        if (if_fire) ifbuf[wr_ptr] <= $signed(if_data);
        if (push)    fifo_mem[fifo_wr] <= psum_word;
    end

    // Datapath
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fs_q      <= '0;
            stride_q  <= '0;
            tap       <= '0;
            ld_tap    <= '0;
            ld_filt   <= '0;
            wr_ptr    <= '0;
            win_start <= '0;
            count     <= '0;
            last_seen <= 1'b0;
            for (int k = 0; k < NUM_FILT; k++) begin
                acc[k] <= '0;
                for (int i = 0; i < MAX_FSIZE; i++) filt[k][i] <= '0;
            end
        end else begin
            if (if_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (if_last) last_seen <= 1'b1;
            end
            // Accept and window release may coincide: net change is +1 - stride.
            count <= count + (if_fire ? CNT_W'(1) : '0) - (push ? CNT_W'(stride_q) : '0);

            case (state)
                IDLE: if (start) begin
                    fs_q     <= fs_eff;
                    stride_q <= st_eff;
                    ld_tap   <= '0;
                    ld_filt  <= '0;
                end
                LOAD_F: if (f_fire) begin
                    filt[ld_filt][ld_tap[TAP_W-1:0]] <= $signed(f_data);
                    if (ld_tap == fs_last) begin
                        ld_tap  <= '0;
                        ld_filt <= ld_filt + FILT_W'(1);
                    end else begin
                        ld_tap <= ld_tap + ONE;
                    end
                end
                WAIT_WIN: begin
                    tap <= '0;
                    for (int k = 0; k < NUM_FILT; k++) acc[k] <= '0;
                end
                MAC: begin
                    tap <= tap + ONE;
                    for (int k = 0; k < NUM_FILT; k++)
                        acc[k] <= acc[k] + ACC_W'(prod[k]);
                end
                STORE: if (push) win_start <= win_start + PTR_W'(stride_q);
                DONE: begin
                    // Drop whatever is left of the row.
                    count     <= '0;
                    win_start <= wr_ptr;
                    last_seen <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (!rst) begin
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) fifo_wr <= (fifo_wr == FPTR_W'(PSUM_DEPTH-1)) ? '0 : fifo_wr + FPTR_W'(1);
            if (pop)  fifo_rd <= (fifo_rd == FPTR_W'(PSUM_DEPTH-1)) ? '0 : fifo_rd + FPTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule
